exp_table_writer: RTL and testbench

//  Writable counterpart of the exp-function lookup tables. Accepts a valid/ready stream of

---
 rtl/exp_table_pkg.sv | 14 +
 rtl/exp_table_writer_ram.sv | 37 +++
 rtl/exp_table_writer.sv | 106 ++++++++++
 tb/tb_exp_table_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp_table_pkg.sv
// Shared definitions for the writable exp lookup table: FSM states and default sizes.
package exp_table_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } tbl_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_RANGE = 32;
  localparam int DEF_ADDR_W     = 5;

endpackage

// File: rtl/exp_table_writer_ram.sv
// Distributed 1W/1R table RAM: synchronous write, registered read that holds when ce=0.
module exp_table_writer_ram
  import exp_table_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_W,
  parameter int Depth        = DEF_ADDR_RANGE,
  parameter int AddressWidth = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AddressWidth-1:0] waddr,
  input  logic [DataWidth-1:0]    wdata,
  input  logic                    ce,
  input  logic [AddressWidth-1:0] raddr,
  output logic [DataWidth-1:0]    q
);

  logic [DataWidth-1:0] mem [Depth];

  // Contents deliberately survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // ---- read stage: q valid one cycle after ce ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ce) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/exp_table_writer.sv
// Writable exp lookup table: streams a full table into RAM, then serves 1-cycle lookups.
module exp_table_writer
  import exp_table_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_W,
  parameter int AddressRange = DEF_ADDR_RANGE,
  parameter int AddressWidth = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [DataWidth-1:0]    wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [AddressWidth:0]   load_count,
  output logic                    load_done,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0,
  output logic                    rd_err
);

  localparam logic [AddressWidth:0] RANGE = (AddressWidth+1)'(AddressRange);
  localparam logic [AddressWidth:0] LAST  = (AddressWidth+1)'(AddressRange - 1);

  function automatic logic [AddressWidth:0] sat_inc(input logic [AddressWidth:0] v);
    return (v >= RANGE) ? RANGE : v + 1'b1;
  endfunction

  tbl_state_e state, state_nxt;
  logic       accept;
  logic       rd_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A restart pulse outranks a beat handshaking in the same cycle.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    load_done = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        wr_ready = 1'b1;
        accept   = wr_valid & ~load_start;
        if (load_start) begin
          state_nxt = LOAD;
        end else if (accept && (load_count == LAST)) begin
          state_nxt = VALID;
        end
      end
      VALID: begin
        load_done = 1'b1;
        if (load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // load_count doubles as the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_count <= '0;
    end else if (load_start) begin
      load_count <= '0;
    end else if (accept) begin
      load_count <= sat_inc(load_count);
    end
  end

  assign rd_ok = ce0 & load_done & ({1'b0, address0} < RANGE);

  // ---- lookup stage: q0 / rd_err one cycle after ce0 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_err <= 1'b0;
    end else begin
      rd_err <= ce0 & ~rd_ok;
    end
  end

  exp_table_writer_ram #(
    .DataWidth   (DataWidth),
    .Depth       (AddressRange),
    .AddressWidth(AddressWidth)
  ) u_ram (
    .clk  (clk),
    .rst  (reset),
    .we   (accept),
    .waddr(load_count[AddressWidth-1:0]),
    .wdata(wr_data),
    .ce   (rd_ok),
    .raddr(address0),
    .q    (q0)
  );

endmodule

// File: tb/tb_exp_table_writer.sv
// Randomized and directed bench for exp_table_writer against a behavioural table model.
module tb_exp_table_writer;

  localparam int DW = 8;
  localparam int AR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW:0]   load_count;
  logic          load_done;
  logic [AW-1:0] address0;
  logic          ce0;
  logic [DW-1:0] q0;
  logic          rd_err;

  exp_table_writer #(
    .DataWidth   (DW),
    .AddressRange(AR),
    .AddressWidth(AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .load_count(load_count),
    .load_done (load_done),
    .address0  (address0),
    .ce0       (ce0),
    .q0        (q0),
    .rd_err    (rd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a table that is either being filled, complete, or neither.
  bit            m_loading;
  bit            m_done;
  int            m_count;
  logic [DW-1:0] m_q;
  bit            m_err;
  logic [DW-1:0] m_mem [AR];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0;
    m_done    = 0;
    m_count   = 0;
    m_q       = '0;
    m_err     = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (ce0) begin
      if (m_done && (int'(address0) < AR)) begin
        m_q   = m_mem[address0];
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      m_err = 0;
    end
    if (load_start) begin
      m_loading = 1;
      m_done    = 0;
      m_count   = 0;
    end else if (m_loading && wr_valid) begin
      m_mem[m_count] = wr_data;
      m_count++;
      if (m_count == AR) begin
        m_loading = 0;
        m_done    = 1;
      end
    end
  endtask

  task automatic compare();
    chk("wr_ready",   32'(wr_ready),   32'(m_loading));
    chk("load_done",  32'(load_done),  32'(m_done));
    chk("load_count", 32'(load_count), 32'(m_count));
    chk("q0",         32'(q0),         32'(m_q));
    chk("rd_err",     32'(rd_err),     32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic ls, input logic v, input logic [DW-1:0] d,
                       input logic ce, input logic [AW-1:0] a);
    load_start = ls;
    wr_valid   = v;
    wr_data    = d;
    ce0        = ce;
    address0   = a;
    step();
  endtask

  initial begin
    int acc;
    reset      = 1'b1;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    ce0        = 1'b0;
    address0   = '0;
    model_reset();
    #1;
    compare();
    step();
    step();
    reset = 1'b0;

    // 1: lookup before any load is rejected
    drive(0, 0, 8'h00, 1, 5'd3);
    chk("t1_rd_err", 32'(rd_err), 32'd1);
    chk("t1_q0", 32'(q0), 32'd0);
    drive(0, 0, 8'h00, 0, 5'd0);
    chk("t1_pulse", 32'(rd_err), 32'd0);

    // 2: back-to-back full load
    drive(1, 0, 8'h00, 0, 5'd0);
    for (int i = 0; i < AR; i++) begin
      chk("t2_ready", 32'(wr_ready), 32'd1);
      drive(0, 1, 8'hA0 + DW'(i), 0, 5'd0);
    end
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_cnt", 32'(load_count), 32'd32);
    drive(0, 0, 8'h00, 1, 5'd5);
    chk("t2_q5", 32'(q0), 32'hA5);

    // 3: throttled load, read back every entry
    drive(1, 0, 8'h00, 0, 5'd0);
    acc = 0;
    for (int c = 0; c < 2 * AR; c++) begin
      drive(0, (c % 2) == 0, 8'hA0 + DW'(acc), 0, 5'd0);
      if ((c % 2) == 0) acc++;
    end
    chk("t3_done", 32'(load_done), 32'd1);
    for (int i = 0; i < AR; i++) begin
      drive(0, 0, 8'h00, 1, AW'(i));
      chk("t3_rd", 32'(q0), 32'hA0 + 32'(i));
    end

    // 5: q0 holds while ce0=0
    drive(0, 0, 8'h00, 1, 5'd7);
    chk("t5_q7", 32'(q0), 32'hA7);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h55, 0, 5'd0);
      chk("t5_hold", 32'(q0), 32'hA7);
    end
    drive(0, 0, 8'h00, 1, 5'd31);
    chk("t5_q31", 32'(q0), 32'hBF);
    chk("t5_err", 32'(rd_err), 32'd0);

    // 4: restart colliding with a beat
    drive(1, 0, 8'h00, 0, 5'd0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'hC0 + DW'(i), 0, 5'd0);
    drive(1, 1, 8'hEE, 0, 5'd0);
    chk("t4_cnt0", 32'(load_count), 32'd0);
    for (int i = 0; i < AR; i++) begin
      chk("t4_notdone", 32'(load_done), 32'd0);
      drive(0, 1, 8'h10 + DW'(i), 0, 5'd0);
    end
    chk("t4_done", 32'(load_done), 32'd1);
    drive(0, 0, 8'h00, 1, 5'd0);
    chk("t4_q0", 32'(q0), 32'h10);

    // 6: reset in the middle of a reload
    drive(1, 0, 8'h00, 0, 5'd0);
    for (int i = 0; i < 20; i++) drive(0, 1, DW'($urandom), 0, 5'd0);
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    chk("t6_done", 32'(load_done), 32'd0);
    chk("t6_ready", 32'(wr_ready), 32'd0);
    chk("t6_q0", 32'(q0), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, DW'($urandom), 1, AW'($urandom));
      chk("t6_rej", 32'(rd_err), 32'd1);
    end

    // Random traffic: occasional restarts, random valid, random lookups
    drive(1, 0, 8'h00, 0, 5'd0);
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), DW'($urandom),
            $urandom_range(0, 1) == 1, AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
